// File: rtl/cw305_crypt_ctrl.sv
// cw305_crypt_ctrl: start/handshake controller sitting between the CW305
// register block and an AES core. A start comes either from the go_i strobe
// or from a rising edge of the synchronized USB trigger. The controller
// snapshots text and key, strobes the core, waits for completion (or aborts
// on timeout), and captures the ciphertext.

module cw305_crypt_ctrl #(
    parameter int pDATA_WIDTH  = 128,
    parameter int pSYNC_STAGES = 2,
    parameter int pTIMEOUT     = 1024
) (
    input  logic                   crypt_clk,
    input  logic                   resetn,
    input  logic                   go_i,
    input  logic                   usb_trigger_i,
    input  logic [pDATA_WIDTH-1:0] textin_i,
    input  logic [pDATA_WIDTH-1:0] key_i,
    output logic                   core_load_o,
    output logic [pDATA_WIDTH-1:0] core_text_o,
    output logic [pDATA_WIDTH-1:0] core_key_o,
    input  logic                   core_done_i,
    input  logic [pDATA_WIDTH-1:0] core_cipher_i,
    output logic [pDATA_WIDTH-1:0] cipherout_o,
    output logic                   busy_o,
    output logic                   trig_o,
    output logic                   timeout_o
);

    localparam int CW = $clog2(pTIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state;
    logic [pSYNC_STAGES-1:0] sync;      // usb_trigger_i synchronizer chain
    logic [pSYNC_STAGES-1:0] sync_vld;  // marks stages holding a post-reset sample
    logic                    sync_prev; // last stage, delayed one cycle
    logic                    armed;     // a genuine low has been seen since reset
    logic                    start_edge;
    logic                    start_evt;
    logic [CW-1:0]           run_cnt;

    // Synchronize the USB trigger and track whether a real low level has been
    // observed, so a trigger held high across reset release cannot fire.
    // NOTE: every clocked register uses <= so all flops sample the values from
    // before the edge; a blocking = here would collapse the synchronizer chain.
    always_ff @(posedge crypt_clk) begin
        if (!resetn) begin
            sync      <= '0;
            sync_vld  <= '0;
            sync_prev <= 1'b0;
            armed     <= 1'b0;
        end else begin
            sync      <= {sync[pSYNC_STAGES-2:0], usb_trigger_i};
            sync_vld  <= {sync_vld[pSYNC_STAGES-2:0], 1'b1};
            sync_prev <= sync[pSYNC_STAGES-1];
            armed     <= armed | (sync_vld[pSYNC_STAGES-1] & ~sync[pSYNC_STAGES-1]);
        end
    end

    // A start edge only counts once the chain has shown a genuine low; go_i and
    // an edge in the same cycle merge into a single start event.
    assign start_edge = armed & sync[pSYNC_STAGES-1] & ~sync_prev;
    assign start_evt  = go_i | start_edge;

    // Control FSM with all outputs registered alongside the state.
    // NOTE: the data registers are cleared on reset so that nothing from a
    // previous session is visible on the core or readback buses after reset.
    always_ff @(posedge crypt_clk) begin
        if (!resetn) begin
            state       <= IDLE;
            run_cnt     <= '0;
            core_load_o <= 1'b0;
            core_text_o <= '0;
            core_key_o  <= '0;
            cipherout_o <= '0;
            busy_o      <= 1'b0;
            trig_o      <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_evt) begin
                        state       <= LOAD;
                        core_text_o <= textin_i;
                        core_key_o  <= key_i;
                        core_load_o <= 1'b1;
                        busy_o      <= 1'b1;
                        trig_o      <= 1'b1;
                        timeout_o   <= 1'b0;
                    end
                end
                LOAD: begin
                    state       <= RUN;
                    core_load_o <= 1'b0;
                    run_cnt     <= '0;
                end
                RUN: begin
                    if (core_done_i) begin
                        // Completion takes priority over a coincident timeout.
                        state       <= DONE;
                        cipherout_o <= core_cipher_i;
                        trig_o      <= 1'b0;
                    end else if (run_cnt == CW'(pTIMEOUT - 1)) begin
                        state     <= IDLE;
                        busy_o    <= 1'b0;
                        trig_o    <= 1'b0;
                        timeout_o <= 1'b1;
                    end else begin
                        run_cnt <= run_cnt + CW'(1);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    core_load_o <= 1'b0;
                    busy_o      <= 1'b0;
                    trig_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cw305_crypt_ctrl.sv
// Directed testbench for cw305_crypt_ctrl. A behavioural core model answers
// load strobes with precomputed AES results for the known vectors.

module tb_cw305_crypt_ctrl;

    localparam int W = 128;

    localparam logic [W-1:0] KEY = 128'habcdef01_12345678_deadbeef_87654321;
    localparam logic [W-1:0] T1  = 128'h12345678_abcdef01_87654321_deadbeef;
    localparam logic [W-1:0] C1  = 128'h8a278bf8fa2812bc39e52c76205af377;
    localparam logic [W-1:0] T2  = 128'h12345678_abcdef01_87654321_deadbe01;
    localparam logic [W-1:0] C2  = 128'h0efee0bff4cf170752994fb45bd45934;

    logic         crypt_clk = 1'b0;
    logic         resetn;
    logic         go_i;
    logic         usb_trigger_i;
    logic [W-1:0] textin_i;
    logic [W-1:0] key_i;
    logic         core_load_o;
    logic [W-1:0] core_text_o;
    logic [W-1:0] core_key_o;
    logic         core_done_i;
    logic [W-1:0] core_cipher_i;
    logic [W-1:0] cipherout_o;
    logic         busy_o;
    logic         trig_o;
    logic         timeout_o;

    // core model state
    logic         model_hang;
    logic         m_done;
    logic [W-1:0] m_cipher;
    logic [W-1:0] m_text;
    logic [W-1:0] m_key;
    int           m_cnt;
    int           loads;
    logic         force_done;
    logic [W-1:0] force_cipher;

    int checks;
    int failures;
    int base;

    always #5 crypt_clk = ~crypt_clk;

    assign core_done_i   = m_done | force_done;
    assign core_cipher_i = force_done ? force_cipher : m_cipher;

    cw305_crypt_ctrl #(
        .pDATA_WIDTH (W),
        .pSYNC_STAGES(2),
        .pTIMEOUT    (16)
    ) dut (
        .crypt_clk    (crypt_clk),
        .resetn       (resetn),
        .go_i         (go_i),
        .usb_trigger_i(usb_trigger_i),
        .textin_i     (textin_i),
        .key_i        (key_i),
        .core_load_o  (core_load_o),
        .core_text_o  (core_text_o),
        .core_key_o   (core_key_o),
        .core_done_i  (core_done_i),
        .core_cipher_i(core_cipher_i),
        .cipherout_o  (cipherout_o),
        .busy_o       (busy_o),
        .trig_o       (trig_o),
        .timeout_o    (timeout_o)
    );

    function automatic logic [W-1:0] aes_lookup(input logic [W-1:0] t, input logic [W-1:0] k);
        if (t == T1 && k == KEY) return C1;
        if (t == T2 && k == KEY) return C2;
        return 128'h0bad;
    endfunction

    // Core model: 1 ns after each rising edge, respond to a load strobe with a
    // done pulse 8 cycles later (unless hung), and count load strobes.
    initial begin
        m_done   = 1'b0;
        m_cipher = '0;
        m_text   = '0;
        m_key    = '0;
        m_cnt    = 0;
        loads    = 0;
        forever begin
            @(posedge crypt_clk);
            #1;
            m_done = 1'b0;
            if (m_cnt != 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_done   = 1'b1;
                    m_cipher = aes_lookup(m_text, m_key);
                end
            end
            if (core_load_o) begin
                loads = loads + 1;
                if (!model_hang) begin
                    m_cnt  = 8;
                    m_text = core_text_o;
                    m_key  = core_key_o;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic pulse_go();
        go_i = 1'b1;
        @(negedge crypt_clk);
        go_i = 1'b0;
    endtask

    // Bounded wait for the model's done pulse, then check capture and busy fall.
    task automatic wait_done(input string tag, input logic [W-1:0] exp_cipher);
        int n = 0;
        while (!core_done_i && n < 40) begin
            @(negedge crypt_clk);
            n++;
        end
        check({tag, "_done_seen"}, W'(core_done_i), W'(1));
        @(negedge crypt_clk);
        check({tag, "_cipher"}, cipherout_o, exp_cipher);
        check({tag, "_busy_in_done"}, W'(busy_o), W'(1));
        check({tag, "_trig_in_done"}, W'(trig_o), W'(0));
        @(negedge crypt_clk);
        check({tag, "_busy_fall"}, W'(busy_o), W'(0));
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        resetn        = 1'b0;
        go_i          = 1'b0;
        usb_trigger_i = 1'b0;
        textin_i      = T1;
        key_i         = KEY;
        model_hang    = 1'b0;
        force_done    = 1'b0;
        force_cipher  = '0;

        // Reset state
        repeat (3) @(negedge crypt_clk);
        check("rst_busy", W'(busy_o), W'(0));
        check("rst_trig", W'(trig_o), W'(0));
        check("rst_timeout", W'(timeout_o), W'(0));
        check("rst_load", W'(core_load_o), W'(0));
        check("rst_cipher", cipherout_o, '0);
        check("rst_text", core_text_o, '0);
        check("rst_key", core_key_o, '0);
        resetn = 1'b1;
        repeat (5) @(negedge crypt_clk);

        // go_i encryption, inputs changed after LOAD must not matter
        base = loads;
        pulse_go();
        check("go_load", W'(core_load_o), W'(1));
        check("go_busy", W'(busy_o), W'(1));
        check("go_trig", W'(trig_o), W'(1));
        check("go_text", core_text_o, T1);
        check("go_key", core_key_o, KEY);
        textin_i = '0;
        key_i    = '1;
        @(negedge crypt_clk);
        check("go_load_one_cycle", W'(core_load_o), W'(0));
        wait_done("go", C1);
        check("go_text_held", core_text_o, T1);
        check("go_loads", W'(loads - base), W'(1));

        // USB trigger held high for 17 cycles gives one encryption
        textin_i = T2;
        key_i    = KEY;
        base     = loads;
        usb_trigger_i = 1'b1;
        repeat (17) @(negedge crypt_clk);
        usb_trigger_i = 1'b0;
        repeat (30) @(negedge crypt_clk);
        check("usb_loads", W'(loads - base), W'(1));
        check("usb_cipher", cipherout_o, C2);
        check("usb_busy", W'(busy_o), W'(0));

        // core_done_i outside RUN is ignored
        force_cipher = '1;
        force_done   = 1'b1;
        @(negedge crypt_clk);
        force_done = 1'b0;
        @(negedge crypt_clk);
        check("idle_done_cipher", cipherout_o, C2);
        check("idle_done_busy", W'(busy_o), W'(0));

        // go_i coincident with a start edge, then go_i re-pulsed during RUN
        textin_i = T1;
        base     = loads;
        usb_trigger_i = 1'b1;
        @(negedge crypt_clk);
        @(negedge crypt_clk);
        pulse_go();
        check("both_load", W'(core_load_o), W'(1));
        repeat (3) @(negedge crypt_clk);
        pulse_go();
        wait_done("both", C1);
        repeat (10) @(negedge crypt_clk);
        check("both_loads", W'(loads - base), W'(1));
        check("both_idle", W'(busy_o), W'(0));
        usb_trigger_i = 1'b0;
        repeat (4) @(negedge crypt_clk);

        // Timeout: hung core, abort after 16 RUN cycles
        model_hang = 1'b1;
        pulse_go();
        repeat (16) @(negedge crypt_clk);
        check("to_busy_before", W'(busy_o), W'(1));
        check("to_flag_before", W'(timeout_o), W'(0));
        @(negedge crypt_clk);
        check("to_flag", W'(timeout_o), W'(1));
        check("to_busy", W'(busy_o), W'(0));
        check("to_trig", W'(trig_o), W'(0));
        check("to_cipher", cipherout_o, C1);
        repeat (3) @(negedge crypt_clk);
        check("to_sticky", W'(timeout_o), W'(1));
        model_hang = 1'b0;
        pulse_go();
        check("to_clear", W'(timeout_o), W'(0));
        wait_done("to_next", C1);

        // Reset mid-RUN, then a late done pulse must be ignored
        model_hang = 1'b1;
        base = loads;
        pulse_go();
        repeat (3) @(negedge crypt_clk);
        resetn = 1'b0;
        @(negedge crypt_clk);
        resetn = 1'b1;
        check("mid_rst_busy", W'(busy_o), W'(0));
        check("mid_rst_trig", W'(trig_o), W'(0));
        check("mid_rst_cipher", cipherout_o, '0);
        check("mid_rst_text", core_text_o, '0);
        force_cipher = '1;
        force_done   = 1'b1;
        @(negedge crypt_clk);
        force_done = 1'b0;
        repeat (2) @(negedge crypt_clk);
        check("late_done_cipher", cipherout_o, '0);
        check("late_done_busy", W'(busy_o), W'(0));
        check("late_done_timeout", W'(timeout_o), W'(0));
        check("late_done_loads", W'(loads - base), W'(1));
        model_hang = 1'b0;

        // USB trigger held high through reset release
        resetn        = 1'b0;
        usb_trigger_i = 1'b1;
        repeat (3) @(negedge crypt_clk);
        resetn = 1'b1;
        base   = loads;
        repeat (10) @(negedge crypt_clk);
        check("held_no_load", W'(loads - base), W'(0));
        check("held_busy", W'(busy_o), W'(0));
        usb_trigger_i = 1'b0;
        repeat (4) @(negedge crypt_clk);
        usb_trigger_i = 1'b1;
        repeat (6) @(negedge crypt_clk);
        check("rearm_load", W'(loads - base), W'(1));
        repeat (20) @(negedge crypt_clk);
        check("rearm_idle", W'(busy_o), W'(0));
        usb_trigger_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
